alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Sequential, handshaked successor of the combinational datapath ALU.
//   Adds shifts, add-with-carry, an iterative multiply and a persistent carry flag.
//   Operands enter on a valid/ready request port. Results and flags are registered
//   and leave on a valid/ready response port. Sits between the decode stage and
//   register-file writeback.
// PARAMETERS
//   word_len  16  operand/result width in bits (>=4)
//   op_len    4   width of the operation code
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         synchronous reset, active low
//   in_valid     in   1         request valid
//   in_ready     out  1         request accepted when in_valid && in_ready
//   x, y         in   word_len  operands
//   operation    in   op_len    opcode, sampled on accept
//   out_valid    out  1         response valid
//   out_ready    in   1         response consumed when out_valid && out_ready
//   ans          out  word_len  registered result
//   did_overflow out  1         signed overflow of the last completed op
//   carry        out  1         carry/borrow/shift-out flag (persistent)
//   is_negative  out  1         ans[word_len-1]
//   is_zero      out  1         ans == 0
//   busy         out  1         state != IDLE
// BEHAVIOUR
//   Reset
//   - On clk edge with rst_n=0: state=IDLE. ans, all flags, out_valid and busy = 0.
//   - An in-flight MUL is aborted and its result discarded.
//   FSM: IDLE, MUL, DONE.
//   - in_ready = (state==IDLE) || (state==DONE && out_ready).
//   - Accept, single-cycle op: result and flags registered on the accept edge;
//     next state DONE. out_valid is high the cycle after accept.
//   - Accept, MUL: load x, y; clear accumulator; cnt=word_len; go to MUL.
//   - MUL: one shift-add step per cycle, LSB of y first. When cnt reaches 0, go to
//     DONE. out_valid rises exactly word_len cycles later than a single-cycle op.
//   - DONE: ans and flags held stable while out_ready=0.
//     If out_ready=1 with no new accept, go to IDLE. If out_ready=1 with a new
//     accept, take the accept path directly (back-to-back).
//   Opcodes (flags reflect the registered ans)
//   - 0 ADD  {c,ans}=x+y.
//   - 1 SUB  ans=x-y; c=borrow (x<y unsigned).
//   - 2 AND, 3 OR, 4 XOR, 5 NOT x.
//   - 6 SHL, 7 SHR logical, 8 ASR.
//     Shift amount = y[$clog2(word_len)-1:0].
//     c = last bit shifted out; amount 0 gives ans=x and c=0.
//   - 9 MUL  ans = low word of x*y (unsigned); c = |high word; did_overflow = c.
//   - 10 ADC {c,ans}=x+y+carry, using the carry flag held before this op.
//   - Other codes: XOR.
//   Flag updates
//   - did_overflow: signed overflow for ADD/SUB/ADC; MUL as above; 0 for all others.
//   - carry: updated only by ADD, SUB, ADC, shifts and MUL; logic ops leave it unchanged.
//   - Flags update only when a result is registered, never while in MUL state.
//   Width rules
//   - All arithmetic is computed at word_len+1 bits.
//   - The multiply accumulator is 2*word_len bits.
//   Protocol
//   - Operands and opcode are ignored outside the accept cycle.
//   - ans must not change while out_valid=1 && out_ready=0.
// TESTING
//   1 ADD x=16'hFFFF y=1 -> ans=0, carry=1, is_zero=1, did_overflow=0;
//     out_valid high the cycle after accept.
//   2 SUB x=16'h8000 y=1 -> ans=16'h7FFF, did_overflow=1, carry=0, is_negative=0.
//   3 MUL x=300 y=300 -> ans=16'h5F90, carry=1, did_overflow=1;
//     in_ready=0 during the 16 MUL cycles.
//   4 ADD 16'hFFFF+1 then ADC 0+0 -> ans=1, carry=0 (carry chain).
//   5 ASR x=16'h8001 y=1 -> ans=16'hC000, carry=1. SHL y=0 -> ans=x, carry=0.
//   6 Backpressure: out_ready=0 for 5 cycles -> ans and flags stable, in_ready=0.
//     Raise out_ready with in_valid=1 -> back-to-back accept.
//   7 rst_n=0 mid-MUL -> next cycle IDLE, out_valid=0, ans=0, carry=0, in_ready=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential, handshaked ALU between decode and register-file writeback.
//
// Single-cycle ops (add/sub/adc, logic, shifts) register their result on the
// accept edge. MUL runs an iterative shift-add over word_len cycles. Results and
// flags are held in registers and offered on a valid/ready response port.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer keeps valid and its payload stable
// until that edge. in_ready is combinational from state and out_ready.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    request handshake; x, y, operation sampled on accept
//   out_valid / out_ready  response handshake; ans and flags are the payload
//   ans                    registered result
//   did_overflow           signed overflow of the last completed op
//   carry                  persistent carry/borrow/shift-out flag
//   is_negative, is_zero   sign and zero flags of the registered ans
//   busy                   high whenever the FSM is not IDLE
//   dbg_state              current FSM state, for observation only

module alu_seq #(
    parameter int word_len = 16,
    parameter int op_len   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [word_len-1:0] x,
    input  logic [word_len-1:0] y,
    input  logic [op_len-1:0]   operation,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [word_len-1:0] ans,
    output logic                did_overflow,
    output logic                carry,
    output logic                is_negative,
    output logic                is_zero,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int W  = word_len;
    localparam int SW = $clog2(word_len);
    localparam int CW = $clog2(word_len + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(word_len);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [op_len-1:0] OP_ADD = op_len'(0);
    localparam logic [op_len-1:0] OP_SUB = op_len'(1);
    localparam logic [op_len-1:0] OP_AND = op_len'(2);
    localparam logic [op_len-1:0] OP_OR  = op_len'(3);
    localparam logic [op_len-1:0] OP_XOR = op_len'(4);
    localparam logic [op_len-1:0] OP_NOT = op_len'(5);
    localparam logic [op_len-1:0] OP_SHL = op_len'(6);
    localparam logic [op_len-1:0] OP_SHR = op_len'(7);
    localparam logic [op_len-1:0] OP_ASR = op_len'(8);
    localparam logic [op_len-1:0] OP_MUL = op_len'(9);
    localparam logic [op_len-1:0] OP_ADC = op_len'(10);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    ans_q;
    logic            ovf_q;
    logic            carry_q;
    logic            neg_q;
    logic            zero_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [2*W-1:0]  mcand_q;
    logic [W-1:0]    mplier_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;

    // Single-cycle datapath, all arithmetic at W+1 bits.
    logic [W:0]      sum_w;
    logic [W:0]      diff_w;
    logic [W:0]      adc_w;
    logic [W:0]      shl_w;
    logic [W:0]      shr_w;
    logic [W:0]      asr_w;
    logic [SW-1:0]   amt;
    logic [W-1:0]    alu_res_d;
    logic            alu_c_d;
    logic            alu_v_d;

    // Multiply step
    logic [2*W-1:0]  acc_d;
    logic            mul_hi_d;

    logic            accept;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);

    always_comb begin
        sum_w  = {1'b0, x} + {1'b0, y};
        diff_w = {1'b0, x} - {1'b0, y};
        adc_w  = sum_w + {{W{1'b0}}, carry_q};
        amt    = y[SW-1:0];
        // A spare bit on the far side of each shift catches the last bit shifted
        // out; with amt==0 that bit is the zero padding, so carry comes out 0.
        shl_w  = {1'b0, x} << amt;
        shr_w  = {x, 1'b0} >> amt;
        asr_w  = $signed({x, 1'b0}) >>> amt;

        alu_res_d = x ^ y;
        alu_c_d   = carry_q;
        alu_v_d   = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_res_d = sum_w[W-1:0];
                alu_c_d   = sum_w[W];
                alu_v_d   = (x[W-1] == y[W-1]) && (sum_w[W-1] != x[W-1]);
            end
            OP_SUB: begin
                alu_res_d = diff_w[W-1:0];
                alu_c_d   = diff_w[W];
                alu_v_d   = (x[W-1] != y[W-1]) && (diff_w[W-1] != x[W-1]);
            end
            OP_ADC: begin
                alu_res_d = adc_w[W-1:0];
                alu_c_d   = adc_w[W];
                alu_v_d   = (x[W-1] == y[W-1]) && (adc_w[W-1] != x[W-1]);
            end
            OP_AND: alu_res_d = x & y;
            OP_OR:  alu_res_d = x | y;
            OP_XOR: alu_res_d = x ^ y;
            OP_NOT: alu_res_d = ~x;
            OP_SHL: begin
                alu_res_d = shl_w[W-1:0];
                alu_c_d   = shl_w[W];
            end
            OP_SHR: begin
                alu_res_d = shr_w[W:1];
                alu_c_d   = shr_w[0];
            end
            OP_ASR: begin
                alu_res_d = asr_w[W:1];
                alu_c_d   = asr_w[0];
            end
            default: begin
                alu_res_d = x ^ y;
            end
        endcase
    end

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
        mul_hi_d = |acc_d[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ans_q       <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else if (accept) begin
            // Reached from IDLE or from DONE with out_ready (back-to-back).
            busy_q <= 1'b1;
            if (operation == OP_MUL) begin
                mcand_q     <= {{W{1'b0}}, x};
                mplier_q    <= y;
                acc_q       <= '0;
                cnt_q       <= CNT_INIT;
                out_valid_q <= 1'b0;
                state_q     <= S_MUL;
            end else begin
                ans_q       <= alu_res_d;
                carry_q     <= alu_c_d;
                ovf_q       <= alu_v_d;
                neg_q       <= alu_res_d[W-1];
                zero_q      <= (alu_res_d == '0);
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_LAST;
                    // Last step: the product is complete in acc_d this cycle.
                    if (cnt_q == CNT_LAST) begin
                        ans_q       <= acc_d[W-1:0];
                        carry_q     <= mul_hi_d;
                        ovf_q       <= mul_hi_d;
                        neg_q       <= acc_d[W-1];
                        zero_q      <= (acc_d[W-1:0] == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // is_zero is a register rather than a decode of ans so that reset leaves
    // every flag low, including while ans itself is zero.
    assign ans          = ans_q;
    assign did_overflow = ovf_q;
    assign carry        = carry_q;
    assign is_negative  = neg_q;
    assign is_zero      = zero_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule
